// File: rtl/sort_out_stream.sv
// Purpose: capture one sorted vector in parallel, stream it out one element per handshake.
// Latency: load accepted at edge N -> element 0 valid in cycle N+1; o_done one cycle after last transfer.
// Backpressure: valid/ready; o_data/o_last held stable while o_valid && !i_ready; i_load ignored while busy.
//
// Ports:
//   i_clk, i_reset     clock (rising edge), asynchronous active-high reset
//   i_load, i_data     capture request (IDLE only) and packed vector, element k at [k*SIZE_DATA +: SIZE_DATA]
//   o_valid, o_data,   current element, i_ready accepts it; o_last marks element NUM_ELEM-1
//   i_ready, o_last
//   o_busy, o_done     busy whenever not IDLE; one-cycle pulse after the last transfer
//   o_order_err        sticky adjacent-order violation flag
//
// Optional feature: define SORT_OUT_ORDER_CHECK_EN to include the order checker;
// without it o_order_err is tied low and streaming is unchanged.

module sort_out_stream #(
  parameter bit IS_ASC    = 1'b1,
  parameter int NUM_ELEM  = 8,
  parameter int SIZE_DATA = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_load,
  input  logic [NUM_ELEM*SIZE_DATA-1:0] i_data,
  output logic                          o_busy,
  output logic                          o_valid,
  output logic [SIZE_DATA-1:0]          o_data,
  input  logic                          i_ready,
  output logic                          o_last,
  output logic                          o_done,
  output logic                          o_order_err
);

  localparam int IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_nxt;
  logic [SIZE_DATA-1:0] vec_q [NUM_ELEM];
  logic [IDX_W-1:0]     idx_q;
  logic                 load_acc;
  logic                 xfer;
  logic                 at_last;

  assign at_last = (idx_q == LAST_IDX);

  // Next-state and outputs. o_data is forced to zero outside STREAM so the
  // bus is quiet whenever o_valid is low.
  always_comb begin
    state_nxt = state_q;
    load_acc  = 1'b0;
    xfer      = 1'b0;
    o_busy    = 1'b0;
    o_valid   = 1'b0;
    o_data    = '0;
    o_last    = 1'b0;
    o_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_load) begin
          load_acc  = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        o_data  = vec_q[idx_q];
        o_last  = at_last;
        xfer    = i_ready;
        if (i_ready && at_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        o_busy    = 1'b1;
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int k = 0; k < NUM_ELEM; k++) begin
        vec_q[k] <= '0;
      end
    end else begin
      state_q <= state_nxt;
      if (load_acc) begin
        idx_q <= '0;
        for (int k = 0; k < NUM_ELEM; k++) begin
          vec_q[k] <= i_data[k*SIZE_DATA +: SIZE_DATA];
        end
      end else if (xfer && !at_last) begin
        // idx stops at LAST_IDX; the final transfer moves the FSM to DONE instead.
        idx_q <= idx_q + 1'b1;
      end
    end
  end

`ifdef SORT_OUT_ORDER_CHECK_EN
  logic [SIZE_DATA-1:0] prev_q;
  logic                 err_q;
  logic                 viol;

  // Element 0 has no predecessor, so only transfers with idx >= 1 are compared.
  always_comb begin
    viol = 1'b0;
    if (xfer && (idx_q != '0)) begin
      viol = IS_ASC ? (o_data < prev_q) : (o_data > prev_q);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (load_acc) begin
        err_q <= 1'b0;
      end else if (viol) begin
        err_q <= 1'b1;
      end
      if (xfer && !at_last) begin
        prev_q <= o_data;
      end
    end
  end

  assign o_order_err = err_q;
`else
  // Direction has no effect without the checker; the flag stays low.
  assign o_order_err = IS_ASC & 1'b0;
`endif

endmodule

// File: tb/tb_sort_out_stream.sv
module tb_sort_out_stream;

`ifdef SORT_OUT_ORDER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        load_a = 1'b0, ready_a = 1'b0;
  logic [63:0] data_a = '0;
  logic        busy_a, valid_a, last_a, done_a, err_a;
  logic [7:0]  dat_a;

  logic        load_d = 1'b0, ready_d = 1'b0;
  logic [63:0] data_d = '0;
  logic        busy_d, valid_d, last_d, done_d, err_d;
  logic [7:0]  dat_d;

  always #5 clk = ~clk;

  sort_out_stream #(.IS_ASC(1'b1), .NUM_ELEM(8), .SIZE_DATA(8)) dut_asc (
    .i_clk(clk), .i_reset(rst), .i_load(load_a), .i_data(data_a),
    .o_busy(busy_a), .o_valid(valid_a), .o_data(dat_a), .i_ready(ready_a),
    .o_last(last_a), .o_done(done_a), .o_order_err(err_a)
  );

  sort_out_stream #(.IS_ASC(1'b0), .NUM_ELEM(8), .SIZE_DATA(8)) dut_desc (
    .i_clk(clk), .i_reset(rst), .i_load(load_d), .i_data(data_d),
    .o_busy(busy_d), .o_valid(valid_d), .o_data(dat_d), .i_ready(ready_d),
    .o_last(last_d), .o_done(done_d), .o_order_err(err_d)
  );

  // Output view of the instance selected by sel (0 = ascending, 1 = descending).
  logic       sel = 1'b0;
  logic       m_busy, m_valid, m_last, m_done, m_err;
  logic [7:0] m_dat;
  assign m_busy  = sel ? busy_d  : busy_a;
  assign m_valid = sel ? valid_d : valid_a;
  assign m_last  = sel ? last_d  : last_a;
  assign m_done  = sel ? done_d  : done_a;
  assign m_err   = sel ? err_d   : err_a;
  assign m_dat   = sel ? dat_d   : dat_a;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        load;
    logic        ready;
    logic [63:0] data;
    logic        busy;
    logic        valid;
    logic [7:0]  dat;
    logic        last;
    logic        done;
    logic        err;
  } row_t;

  row_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic chk_all(input string tag, input logic busy, input logic valid,
                         input logic [7:0] dat, input logic last, input logic done, input logic err);
    chk({tag, ".busy"},  m_busy,  busy);
    chk({tag, ".valid"}, m_valid, valid);
    chk({tag, ".data"},  m_dat,   dat);
    chk({tag, ".last"},  m_last,  last);
    chk({tag, ".done"},  m_done,  done);
    chk({tag, ".err"},   m_err,   err);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pk(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [7:0] el(input logic [63:0] v, input int k);
    return v[k*8 +: 8];
  endfunction

  function automatic row_t mk(input logic load, ready, input logic [63:0] data,
                              input logic busy, valid, input logic [7:0] dat,
                              input logic last, done, err);
    row_t r;
    r.load = load; r.ready = ready; r.data = data; r.busy = busy; r.valid = valid;
    r.dat = dat; r.last = last; r.done = done; r.err = err;
    return r;
  endfunction

  task automatic drive(input logic load, input logic ready, input logic [63:0] data);
    if (sel) begin load_d = load; ready_d = ready; data_d = data; end
    else     begin load_a = load; ready_a = ready; data_a = data; end
  endtask

  // Load vec from IDLE with i_ready held high and check every cycle through
  // DONE and back to IDLE. bad_k is the index of the offending transfer (-1: none).
  task automatic stream_check(input string tag, input logic [63:0] vec, input int bad_k);
    logic e;
    drive(1'b1, 1'b1, vec);
    chk({tag, ".idle_busy"}, m_busy, 1'b0);
    tick();
    drive(1'b0, 1'b1, 64'h0);
    for (int k = 0; k < 8; k++) begin
      e = CHK && (bad_k >= 0) && (k > bad_k);
      chk_all($sformatf("%s.e%0d", tag, k), 1'b1, 1'b1, el(vec, k), k == 7, 1'b0, e);
      tick();
    end
    e = CHK && (bad_k >= 0);
    chk_all({tag, ".done"}, 1'b1, 1'b0, 8'h0, 1'b0, 1'b1, e);
    tick();
    chk_all({tag, ".back_idle"}, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, e);
  endtask

  logic [63:0] v1, v2, v3, v4;
  int e_idx;
  logic rdy;

  initial begin
    v1 = pk(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    v2 = pk(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80);
    v3 = pk(8'd1, 8'd2, 8'd9, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    v4 = pk(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0);

    // Ascending stream, ready held high.
    tbl.push_back(mk(1, 1, v1, 0, 0, 8'd0, 0, 0, 0));
    for (int k = 0; k < 8; k++) tbl.push_back(mk(0, 1, 64'h0, 1, 1, 8'(k + 1), k == 7, 0, 0));
    tbl.push_back(mk(0, 1, 64'h0, 1, 0, 8'd0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 64'h0, 0, 0, 8'd0, 0, 0, 0));
    // Backpressure: ready pattern 1,0,0 repeating; element advances only on ready.
    tbl.push_back(mk(1, 0, v1, 0, 0, 8'd0, 0, 0, 0));
    e_idx = 0;
    for (int i = 0; e_idx < 8; i++) begin
      rdy = (i % 3 == 0);
      tbl.push_back(mk(0, rdy, 64'h0, 1, 1, 8'(e_idx + 1), e_idx == 7, 0, 0));
      if (rdy) e_idx++;
    end
    tbl.push_back(mk(0, 0, 64'h0, 1, 0, 8'd0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 64'h0, 0, 0, 8'd0, 0, 0, 0));

    // Reset held 5 cycles, then idle with no load.
    rst = 1'b1;
    ready_d = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_all("rst_hold", 0, 0, 8'h0, 0, 0, 0);
    rst = 1'b0;
    ready_a = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_all($sformatf("idle%0d", c), 0, 0, 8'h0, 0, 0, 0);
    end

    // Table-driven rows on the ascending instance.
    sel = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].load, tbl[i].ready, tbl[i].data);
      #1;
      chk_all($sformatf("row%0d", i), tbl[i].busy, tbl[i].valid, tbl[i].dat,
              tbl[i].last, tbl[i].done, tbl[i].err);
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b1, 64'h0);

    // Order checking: mid-stream violation, cleared by next load, violation on last element.
    stream_check("viol_mid", v3, 3);
    stream_check("clear", v1, -1);
    stream_check("viol_last", v4, 7);
    sel = 1'b1;
    stream_check("desc_eq", pk(8'd8, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2), -1);
    stream_check("desc_viol", pk(8'd5, 8'd6, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0), 1);
    sel = 1'b0;

    // Load while busy is ignored.
    drive(1'b1, 1'b1, v1);
    tick();
    drive(1'b0, 1'b1, 64'h0);
    chk("lwb.e0", dat_a, 8'd1);
    tick();
    chk("lwb.e1", dat_a, 8'd2);
    drive(1'b1, 1'b1, v2);
    tick();
    drive(1'b0, 1'b1, 64'h0);
    for (int k = 2; k < 8; k++) begin
      chk($sformatf("lwb.e%0d", k), dat_a, el(v1, k));
      tick();
    end
    chk("lwb.done", done_a, 1'b1);
    tick();
    drive(1'b1, 1'b1, v2);
    tick();
    drive(1'b0, 1'b1, 64'h0);
    chk("lwb.new_e0", dat_a, 8'd10);

    // Reset mid-stream after 3 transfers: outputs clear immediately.
    tick();
    tick();
    tick();
    chk("rms.e3", dat_a, 8'd40);
    #2;
    rst = 1'b1;
    #1;
    chk_all("rms.async", 0, 0, 8'h0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all("rms.released", 0, 0, 8'h0, 0, 0, 0);
    stream_check("rms.fresh", v1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
